fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address/PC width.
REQ-002 SHALL have parameter DWIDTH, default 32, instruction width.
REQ-003 SHALL have parameter BASEADDR, default IMEM_BASE_ADDR, PC value after reset.
REQ-004 SHALL have parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port imem_addr_o  output  AWIDTH  instruction memory read address (= fetch PC).
REQ-008 SHALL have port imem_read_en_o  output  1  memory read request; high exactly on push cycles.
REQ-009 SHALL have port imem_data_i  input  DWIDTH  instruction word, valid in the same cycle as imem_addr_o.
REQ-010 SHALL have port redirect_i  input  1  flush queue and restart fetch at redirect_pc_i.
REQ-011 SHALL have port redirect_pc_i  input  AWIDTH  redirect target.
REQ-012 SHALL have port valid_o  output  1  head entry available to decode.
REQ-013 SHALL have port ready_i  input  1  decode accepts head entry.
REQ-014 SHALL have port pc_o  output  AWIDTH  PC of head entry.
REQ-015 SHALL have port insn_o  output  DWIDTH  instruction of head entry.
REQ-016 SHALL have port count_o  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-017 SHALL drive imem_addr_o from registered fetch PC at all times.
REQ-018 SHALL define pop = valid_o && ready_i; push = !redirect_i && (count < DEPTH || pop).
REQ-019 SHALL on push write {imem_addr_o, imem_data_i} at tail, advance tail, and increment fetch PC by 4 (modulo 2^AWIDTH).
REQ-020 SHALL on pop advance head; count updates by +push -pop in the same edge (push and pop together leave count unchanged).
REQ-021 SHALL, when full and pop, accept a push in the same cycle (no bubble).
REQ-022 SHALL, when full and no pop, hold PC, deassert imem_read_en_o, and write nothing.
REQ-023 SHALL drive valid_o = (count != 0), pc_o/insn_o from head entry; both registered-state-derived, no combinational path from ready_i or imem_data_i.
REQ-024 SHALL give 1-cycle latency: a word pushed at edge N is presented with valid_o high after edge N.
REQ-025 SHALL hold pc_o/insn_o stable while valid_o && !ready_i.
REQ-026 SHALL on redirect_i (highest priority) at the next edge: empty the queue (head=tail=0, count=0), set PC = {redirect_pc_i[AWIDTH-1:2], 2'b00}, suppress push; a concurrent pop handshake is considered consumed.
REQ-027 SHALL wrap head/tail pointers modulo DEPTH.
REQ-028 SHALL treat the cycle after redirect as a normal fetch from the new PC.

Reset
REQ-029 SHALL on rst at rising edge set PC = BASEADDR, head = tail = count = 0; outputs valid_o = 0, count_o = 0, imem_addr_o = BASEADDR.
REQ-030 SHALL give rst priority over redirect_i, push and pop; reset mid-stream discards all entries.
REQ-031 SHALL not require storage array reset; pc_o/insn_o content is don't-care while valid_o = 0.

Structure
REQ-032 SHALL place entry typedef fq_entry_t {pc, insn} and the default DEPTH constant in the shared constants package/header.
REQ-033 SHALL implement storage as one sub-module sync_fifo (push/pop/flush, count), with PC and redirect logic in fetch_queue.

Verification
REQ-034 Reset release, ready_i=1, BASEADDR=0x01000000 -> imem addresses 0x01000000, 0x01000004, ...; first valid_o one cycle later with pc_o=0x01000000.
REQ-035 ready_i=0 for 6 cycles -> 4 pushes, count_o=4, imem_read_en_o=0, PC held at 0x01000010.
REQ-036 Full queue, ready_i=1 for one cycle -> pop 0x01000000 and push 0x01000010 same edge, count_o stays 4.
REQ-037 Queue count 3, redirect_i=1 with redirect_pc_i=0x01000103 -> next cycle count_o=0, imem_addr_o=0x01000100, one cycle later pc_o=0x01000100.
REQ-038 rst asserted with count 2 and redirect_i=1 same cycle -> count_o=0, imem_addr_o=BASEADDR.
REQ-039 Random ready_i over 1000 cycles with model memory -> insn_o/pc_o sequence matches sequential PCs, no loss or duplication.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared constants and entry type for the fetch queue
package fetch_queue_pkg;

  localparam logic [31:0] IMEM_BASE_ADDR = 32'h0100_0000;
  localparam int          FQ_DEPTH       = 4;
  localparam int          FQ_AWIDTH      = 32;
  localparam int          FQ_DWIDTH      = 32;

  typedef struct packed {
    logic [FQ_AWIDTH-1:0] pc;
    logic [FQ_DWIDTH-1:0] insn;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// rtl/fetch_queue_sync_fifo.sv - fetch queue storage: synchronous fifo with flush
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  // Storage is never reset; the head word is only meaningful while count != 0.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem[tail] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[head];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue: PC generation, redirect and decode handshake
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                AWIDTH   = 32,
  parameter int                DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(IMEM_BASE_ADDR),
  parameter int                DEPTH    = FQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [AWIDTH-1:0]          imem_addr_o,
  output logic                       imem_read_en_o,
  input  logic [DWIDTH-1:0]          imem_data_i,
  input  logic                       redirect_i,
  input  logic [AWIDTH-1:0]          redirect_pc_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [AWIDTH-1:0]          pc_o,
  output logic [DWIDTH-1:0]          insn_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH+1);

  logic [AWIDTH-1:0]        pc_q;
  logic                     pop;
  logic                     push;
  logic [AWIDTH+DWIDTH-1:0] rdata;

  assign valid_o        = (count_o != '0);
  assign pop            = valid_o && ready_i;
  // A full queue can still take a word when the head leaves in the same cycle.
  assign push           = !redirect_i && ((count_o < CW'(DEPTH)) || pop);
  assign imem_read_en_o = push;
  assign imem_addr_o    = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= BASEADDR;
    end else if (redirect_i) begin
      pc_q <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
    end else if (push) begin
      pc_q <= pc_q + AWIDTH'(4);
    end
  end

  sync_fifo #(
    .WIDTH (AWIDTH + DWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_i),
    .push  (push),
    .pop   (pop),
    .wdata ({pc_q, imem_data_i}),
    .rdata (rdata),
    .count (count_o)
  );

  assign pc_o   = rdata[AWIDTH+DWIDTH-1:DWIDTH];
  assign insn_o = rdata[DWIDTH-1:0];

endmodule
